instr_fetch_unit: RTL and testbench

- Fetch stage of the single-cycle-to-multicycle MIPS datapath.
- Owns the PC and issues word reads to instruction memory, one outstanding at a time.
- Presents each fetched instruction to decode with a valid/ready handshake, pre-split into opcode and fn_code fields for the main control unit.
- Accepts branch/jump redirects from execute and squashes any in-flight fetch.

---
 rtl/instr_fetch_unit_pkg.sv | 31 +++
 rtl/instr_fetch_unit_out_reg.sv | 35 +++
 rtl/instr_fetch_unit.sv | 133 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the MIPS fetch stage and the main control unit decode.
package instr_fetch_unit_pkg;

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT} state_t;

   localparam int unsigned INSTR_W    = 32;
   localparam int unsigned OPCODE_MSB = 31;
   localparam int unsigned OPCODE_LSB = 26;
   localparam int unsigned FN_MSB     = 5;
   localparam int unsigned FN_LSB     = 0;
   localparam int unsigned PC_STEP    = 4;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_SRL   = 6'b000010;

   function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] instr);
      return instr[OPCODE_MSB:OPCODE_LSB];
   endfunction

   function automatic logic [5:0] fn_code_of(input logic [INSTR_W-1:0] instr);
      return instr[FN_MSB:FN_LSB];
   endfunction

endpackage

// File: rtl/instr_fetch_unit_out_reg.sv
// ifu_out_reg: holds the fetched instruction and its PC for decode until consumed or flushed.
module ifu_out_reg
   import instr_fetch_unit_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               flush,
   input  logic               ready,
   input  logic [INSTR_W-1:0] load_instr,
   input  logic [ADDR_W-1:0]  load_pc,
   output logic               valid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  pc
);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         instr <= '0;
         pc    <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         instr <= load_instr;
         pc    <= load_pc;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, one outstanding imem read, valid/ready hand-off to decode.
// Optional perf counters enabled by defining IFU_PERF_CNT_EN.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT[ADDR_W-1:0]
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [ADDR_W-1:0]  imem_req_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               if_valid,
   input  logic               if_ready,
   output logic [INSTR_W-1:0] if_instr,
   output logic [ADDR_W-1:0]  if_pc,
   output logic [5:0]         if_opcode,
   output logic [5:0]         if_fn_code
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0]        perf_fetched,
   output logic [31:0]        perf_squashed
`endif
);

   localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(PC_STEP);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

   state_t             state;
   logic [ADDR_W-1:0]  pc;
   logic               squash;
   logic [ADDR_W-1:0]  redirect_target;
   logic               out_load;
   logic               out_flush;
   logic               rsp_drop;

   assign redirect_target = redirect_pc & ALIGN_MASK;
   assign imem_req_valid  = (state == S_REQ) && !rst;
   assign imem_req_addr   = pc;

   always_comb begin
      out_load  = (state == S_WAIT) && imem_rsp_valid && !squash && !redirect_valid;
      out_flush = (state == S_OUT) && redirect_valid;
      rsp_drop  = (state == S_WAIT) && imem_rsp_valid && (squash || redirect_valid);
   end

   // Redirect wins in every state; a fetch already accepted by memory is marked
   // for squash so its late response is discarded instead of delivered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_REQ;
         pc     <= RESET_PC;
         squash <= 1'b0;
      end else begin
         case (state)
            S_REQ: begin
               if (redirect_valid) pc <= redirect_target;
               if (imem_req_ready) begin
                  state <= S_WAIT;
                  if (redirect_valid) squash <= 1'b1;
               end
            end
            S_WAIT: begin
               if (redirect_valid) begin
                  pc <= redirect_target;
                  if (imem_rsp_valid) begin
                     squash <= 1'b0;
                     state  <= S_REQ;
                  end else begin
                     squash <= 1'b1;
                  end
               end else if (imem_rsp_valid) begin
                  if (squash) begin
                     squash <= 1'b0;
                     state  <= S_REQ;
                  end else begin
                     pc    <= pc + PC_INC;
                     state <= S_OUT;
                  end
               end
            end
            S_OUT: begin
               if (redirect_valid) begin
                  pc    <= redirect_target;
                  state <= S_REQ;
               end else if (if_ready) begin
                  state <= S_REQ;
               end
            end
            default: state <= S_REQ;
         endcase
      end
   end

   ifu_out_reg #(.ADDR_W(ADDR_W)) u_out_reg (
      .clk        (clk),
      .rst        (rst),
      .load       (out_load),
      .flush      (out_flush),
      .ready      (if_ready),
      .load_instr (imem_rsp_data),
      .load_pc    (pc),
      .valid      (if_valid),
      .instr      (if_instr),
      .pc         (if_pc)
   );

   assign if_opcode  = opcode_of(if_instr);
   assign if_fn_code = fn_code_of(if_instr);

`ifdef IFU_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched  <= '0;
         perf_squashed <= '0;
      end else begin
         if (if_valid && if_ready && (perf_fetched != '1))
            perf_fetched <= perf_fetched + 32'd1;
         if (rsp_drop && (perf_squashed != '1))
            perf_squashed <= perf_squashed + 32'd1;
      end
   end
`else
   logic unused_drop;
   assign unused_drop = rsp_drop;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a delivery scoreboard; IFU_PERF_CNT_EN adds counter checks.
module tb_instr_fetch_unit;
   import instr_fetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [5:0]  if_opcode;
   logic [5:0]  if_fn_code;
`ifdef IFU_PERF_CNT_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_squashed;
`endif

   instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_opcode      (if_opcode),
      .if_fn_code     (if_fn_code)
`ifdef IFU_PERF_CNT_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_squashed  (perf_squashed)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;
   int unsigned exp_fetched  = 0;
   int unsigned exp_squashed = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Each instruction handed to decode must match the oldest expected delivery.
   always @(negedge clk) begin
      if (!rst && if_valid && if_ready) begin
         exp_fetched++;
         if (sb.size() == 0) begin
            check("unexpected_delivery", {32'h0, if_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_instr",  {32'h0, if_instr}, {32'h0, e.instr});
            check("sb_pc",     {32'h0, if_pc},    {32'h0, e.pc});
            check("sb_opcode", {58'h0, if_opcode},  {58'h0, e.instr[31:26]});
            check("sb_fn",     {58'h0, if_fn_code}, {58'h0, e.instr[5:0]});
         end
      end
   end

   task automatic expect_req(input string tag, input logic [31:0] addr);
      int unsigned n = 0;
      while (!imem_req_valid && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_req_valid"}, {63'h0, imem_req_valid}, 64'h1);
      check({tag, "_req_addr"}, {32'h0, imem_req_addr}, {32'h0, addr});
   endtask

   task automatic accept();
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
   endtask

   task automatic respond(input logic [31:0] data);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data;
      tick();
      imem_rsp_valid = 1'b0;
   endtask

   // Full zero-wait fetch consumed immediately by decode.
   task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
      exp_t e;
      expect_req(tag, addr);
      accept();
      e.pc = addr;
      e.instr = data;
      sb.push_back(e);
      respond(data);
      check({tag, "_if_valid"}, {63'h0, if_valid}, 64'h1);
      if_ready = 1'b1;
      tick();
      check({tag, "_if_valid_clr"}, {63'h0, if_valid}, 64'h0);
   endtask

   initial begin
      exp_t e;
      logic [31:0] held_instr;
      rst            = 1'b1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      if_ready       = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
      check("rst_if_valid",  {63'h0, if_valid}, 64'h0);
      check("rst_if_instr",  {32'h0, if_instr}, 64'h0);
      check("rst_if_pc",     {32'h0, if_pc}, 64'h0);
      rst = 1'b0;

      // First fetch: latency 2 cycles, then decode stalls for 5 cycles
      expect_req("first", 32'h0);
      accept();
      check("first_wait_no_req", {63'h0, imem_req_valid}, 64'h0);
      e.pc = 32'h0;
      e.instr = 32'h0000_0020;
      sb.push_back(e);
      respond(32'h0000_0020);
      check("lat_if_valid", {63'h0, if_valid}, 64'h1);
      check("lat_if_pc",    {32'h0, if_pc}, 64'h0);
      check("lat_opcode",   {58'h0, if_opcode}, 64'h0);
      check("lat_fn",       {58'h0, if_fn_code}, 64'h20);
      held_instr = if_instr;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_valid", {63'h0, if_valid}, 64'h1);
         check("hold_instr", {32'h0, if_instr}, {32'h0, held_instr});
         check("hold_pc",    {32'h0, if_pc}, 64'h0);
         check("hold_no_req", {63'h0, imem_req_valid}, 64'h0);
      end
      if_ready = 1'b1;
      tick();
      check("release_valid", {63'h0, if_valid}, 64'h0);
      expect_req("release", 32'h4);

      // Redirect during S_WAIT, stale response 3 cycles later is dropped
      accept();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      tick();
      redirect_valid = 1'b0;
      tick();
      tick();
      check("sq_wait_no_req", {63'h0, imem_req_valid}, 64'h0);
      respond(32'hDEAD_BEEF);
      exp_squashed++;
      check("sq_no_valid", {63'h0, if_valid}, 64'h0);
      expect_req("sq_next", 32'h0000_0100);
      fetch("rtype_add", 32'h0000_0100, {OP_RTYPE, 5'd1, 5'd2, 5'd3, 5'd0, FN_ADD});

      // Redirect in the same cycle as the response
      expect_req("same", 32'h0000_0104);
      accept();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h1234_5678;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      tick();
      imem_rsp_valid = 1'b0;
      redirect_valid = 1'b0;
      exp_squashed++;
      check("same_no_valid", {63'h0, if_valid}, 64'h0);
      expect_req("same_next", 32'h0000_0200);

      // Redirect in S_REQ without acceptance, then with acceptance
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0303;
      tick();
      expect_req("req_redir", 32'h0000_0300);
      redirect_pc    = 32'hFFFF_FFFC;
      imem_req_ready = 1'b1;
      tick();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b0;
      respond(32'hCAFE_F00D);
      exp_squashed++;
      check("acc_redir_no_valid", {63'h0, if_valid}, 64'h0);

      // PC wrap from the top of the address space
      fetch("wrap", 32'hFFFF_FFFC, {OP_RTYPE, 5'd4, 5'd5, 5'd6, 5'd0, FN_SUB});
      expect_req("wrap_next", 32'h0000_0000);

      // Redirect while holding an instruction flushes it
      if_ready = 1'b0;
      accept();
      respond(32'h0000_0002);
      check("out_redir_valid_pre", {63'h0, if_valid}, 64'h1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0040;
      tick();
      redirect_valid = 1'b0;
      check("out_redir_flush", {63'h0, if_valid}, 64'h0);
      expect_req("out_redir_next", 32'h0000_0040);

      // Reset while in S_OUT
      accept();
      respond(32'h0000_0024);
      check("rst_out_valid_pre", {63'h0, if_valid}, 64'h1);
`ifdef IFU_PERF_CNT_EN
      check("perf_fetched",  {32'h0, perf_fetched},  {32'h0, exp_fetched});
      check("perf_squashed", {32'h0, perf_squashed}, {32'h0, exp_squashed});
`endif
      rst = 1'b1;
      tick();
      check("rst_out_valid", {63'h0, if_valid}, 64'h0);
      check("rst_out_no_req", {63'h0, imem_req_valid}, 64'h0);
      rst = 1'b0;
`ifdef IFU_PERF_CNT_EN
      check("perf_fetched_rst",  {32'h0, perf_fetched},  64'h0);
      check("perf_squashed_rst", {32'h0, perf_squashed}, 64'h0);
`endif
      fetch("post_rst", 32'h0000_0000, {OP_RTYPE, 5'd7, 5'd8, 5'd9, 5'd2, FN_SRL});
      expect_req("post_rst_next", 32'h0000_0004);

      tick();
      check("sb_empty", {32'h0, sb.size()}, 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
